// File: rtl/updown_sweep_ctrl.sv
// ---------------------------------------------------------------------------
// updown_sweep_ctrl
//
// This block sequences a free-running 4-bit up/down counter. The counter has
// no enable, so it steps every clock. The controller drives the counter's
// rst/updo inputs, watches its count, and runs commanded triangle sweeps
// between lo and hi for a given number of legs. While idle it holds the
// counter cleared. It reports completion with a status code and flags any
// count that leaves the commanded range.
//
// Ports
//   clk          in   clock; all logic updates on the rising edge
//   rst          in   synchronous reset, active low
//   cmd_valid    in   a command is offered
//   cmd_ready    out  the controller can take a command (idle and not in reset)
//   cmd_lo       in   lower sweep bound [W]
//   cmd_hi       in   upper sweep bound [W]
//   cmd_legs     in   number of legs to run [LEG_W]
//   abort        in   stop the active sweep
//   cnt_rst      out  counter clear, active high, registered
//   cnt_updo     out  counter direction (1 = up), registered
//   cnt_count    in   counter output [W]
//   busy         out  a sweep is in progress (SEEK or SWEEP)
//   done         out  one-cycle pulse at the end of every accepted command
//   done_status  out  qualified by done: 00 ok, 01 aborted, 10 bad cmd,
//                     11 range error
// ---------------------------------------------------------------------------
module updown_sweep_ctrl #(
   parameter int W     = 4,
   parameter int LEG_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [W-1:0]     cmd_lo,
   input  logic [W-1:0]     cmd_hi,
   input  logic [LEG_W-1:0] cmd_legs,
   input  logic             abort,
   output logic             cnt_rst,
   output logic             cnt_updo,
   input  logic [W-1:0]     cnt_count,
   output logic             busy,
   output logic             done,
   output logic [1:0]       done_status
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SEEK  = 2'd1,
      SWEEP = 2'd2
   } state_t;

   localparam logic [1:0] ST_OK    = 2'b00;
   localparam logic [1:0] ST_ABORT = 2'b01;
   localparam logic [1:0] ST_BAD   = 2'b10;
   localparam logic [1:0] ST_RANGE = 2'b11;

   localparam logic [W-1:0]     ONE_W   = {{(W-1){1'b0}}, 1'b1};
   localparam logic [LEG_W-1:0] ONE_LEG = {{(LEG_W-1){1'b0}}, 1'b1};

   state_t           state_q;
   logic             cnt_rst_q;
   logic             cnt_updo_q;
   logic             done_q;
   logic [1:0]       status_q;
   logic [W-1:0]     lo_q;
   logic [W-1:0]     hi_q;
   logic [LEG_W-1:0] legs_left_q;

   // The direction output is registered, so the counter takes one more step
   // in the old direction after we decide to turn. Every turnaround therefore
   // fires one count before the bound.
   logic [W-1:0] lo_m1;
   logic [W-1:0] lo_p1;
   logic [W-1:0] hi_m1;
   logic         turn_hit;
   logic         out_of_range;

   assign lo_m1        = lo_q - ONE_W;
   assign lo_p1        = lo_q + ONE_W;
   assign hi_m1        = hi_q - ONE_W;
   // cnt_updo_q doubles as the current sweep direction.
   assign turn_hit     = cnt_updo_q ? (cnt_count == hi_m1) : (cnt_count == lo_p1);
   assign out_of_range = (cnt_count < lo_q) || (cnt_count > hi_q);

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= IDLE;
         cnt_rst_q   <= 1'b1;
         cnt_updo_q  <= 1'b1;
         done_q      <= 1'b0;
         status_q    <= ST_OK;
         lo_q        <= '0;
         hi_q        <= '0;
         legs_left_q <= '0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               cnt_rst_q  <= 1'b1;
               cnt_updo_q <= 1'b1;
               if (cmd_valid) begin
                  lo_q        <= cmd_lo;
                  hi_q        <= cmd_hi;
                  legs_left_q <= cmd_legs;
                  if ((cmd_lo >= cmd_hi) || (cmd_legs == '0)) begin
                     done_q   <= 1'b1;
                     status_q <= ST_BAD;
                  end else begin
                     // Release the counter; it starts from 0 and counts up.
                     cnt_rst_q <= 1'b0;
                     state_q   <= (cmd_lo == '0) ? SWEEP : SEEK;
                  end
               end
            end

            SEEK: begin
               if (abort) begin
                  state_q    <= IDLE;
                  cnt_rst_q  <= 1'b1;
                  cnt_updo_q <= 1'b1;
                  done_q     <= 1'b1;
                  status_q   <= ST_ABORT;
               end else if (cnt_count == lo_m1) begin
                  state_q <= SWEEP;
               end
            end

            SWEEP: begin
               // Priority: abort, then range error, then turnaround or finish.
               if (abort) begin
                  state_q    <= IDLE;
                  cnt_rst_q  <= 1'b1;
                  cnt_updo_q <= 1'b1;
                  done_q     <= 1'b1;
                  status_q   <= ST_ABORT;
               end else if (out_of_range) begin
                  state_q    <= IDLE;
                  cnt_rst_q  <= 1'b1;
                  cnt_updo_q <= 1'b1;
                  done_q     <= 1'b1;
                  status_q   <= ST_RANGE;
               end else if (turn_hit) begin
                  legs_left_q <= legs_left_q - ONE_LEG;
                  if (legs_left_q == ONE_LEG) begin
                     // The counter still lands on the final bound this edge,
                     // so the bound is visible during the done cycle.
                     state_q    <= IDLE;
                     cnt_rst_q  <= 1'b1;
                     cnt_updo_q <= 1'b1;
                     done_q     <= 1'b1;
                     status_q   <= ST_OK;
                  end else begin
                     cnt_updo_q <= ~cnt_updo_q;
                  end
               end
            end

            default: begin
               state_q   <= IDLE;
               cnt_rst_q <= 1'b1;
            end
         endcase
      end
   end

   assign cmd_ready   = (state_q == IDLE) && rst;
   assign busy        = (state_q == SEEK) || (state_q == SWEEP);
   assign cnt_rst     = cnt_rst_q;
   assign cnt_updo    = cnt_updo_q;
   assign done        = done_q;
   assign done_status = status_q;

endmodule

// File: tb/tb_updown_sweep_ctrl.sv
// ---------------------------------------------------------------------------
// tb_updown_sweep_ctrl
//
// Bench for updown_sweep_ctrl. It contains a behavioural model of the 4-bit
// up/down counter. Each command pushes its expected per-cycle trace
// (count, done, status, busy, cnt_rst) into a scoreboard queue. The trace is
// then popped and compared one entry per cycle on the falling edge.
// ---------------------------------------------------------------------------
module tb_updown_sweep_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [3:0] cmd_lo;
   logic [3:0] cmd_hi;
   logic [7:0] cmd_legs;
   logic       abort;
   logic       cnt_rst;
   logic       cnt_updo;
   logic [3:0] cnt_count;
   logic       busy;
   logic       done;
   logic [1:0] done_status;

   logic [3:0] model_cnt = 4'd0;
   logic       force_en  = 1'b0;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [3:0] cnt;
      logic       done;
      logic [1:0] st;
      logic       busy;
      logic       crst;
   } exp_t;

   exp_t sb[$];

   always #5 clk = ~clk;

   // Counter datapath model: no enable, steps every edge.
   always @(posedge clk)
      model_cnt <= cnt_rst ? 4'd0 : (cnt_updo ? model_cnt + 4'd1 : model_cnt - 4'd1);

   assign cnt_count = force_en ? 4'd12 : model_cnt;

   updown_sweep_ctrl #(.W(4), .LEG_W(8)) dut (
      .clk         (clk),
      .rst         (rst),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_lo      (cmd_lo),
      .cmd_hi      (cmd_hi),
      .cmd_legs    (cmd_legs),
      .abort       (abort),
      .cnt_rst     (cnt_rst),
      .cnt_updo    (cnt_updo),
      .cnt_count   (cnt_count),
      .busy        (busy),
      .done        (done),
      .done_status (done_status)
   );

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [3:0] c, input logic d, input logic [1:0] s,
                       input logic b, input logic r);
      exp_t e;
      e.cnt = c; e.done = d; e.st = s; e.busy = b; e.crst = r;
      sb.push_back(e);
   endtask

   // Busy cycles with the counter running from a to b inclusive.
   task automatic push_ramp(input int a, input int b);
      if (a <= b) begin
         for (int v = a; v <= b; v++) push(4'(v), 1'b0, 2'b00, 1'b1, 1'b0);
      end else begin
         for (int v = a; v >= b; v--) push(4'(v), 1'b0, 2'b00, 1'b1, 1'b0);
      end
   endtask

   task automatic push_done(input logic [3:0] c, input logic [1:0] s);
      push(c, 1'b1, s, 1'b0, 1'b1);
   endtask

   task automatic push_idle(input logic [3:0] c);
      push(c, 1'b0, 2'b00, 1'b0, 1'b1);
   endtask

   task automatic issue(input logic [3:0] lo, input logic [3:0] hi, input logic [7:0] legs);
      @(negedge clk);
      cmd_lo    = lo;
      cmd_hi    = hi;
      cmd_legs  = legs;
      cmd_valid = 1'b1;
      #1;
      chk("ready_at_issue", {7'b0, cmd_ready}, 8'd1);
      $display("cmd lo=%0d hi=%0d legs=%0d expected_cycles=%0d", lo, hi, legs, sb.size());
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
   endtask

   // hook_kind: 0 none, 1 abort, 2 force count=12, 3 rst low, 4 drop cmd_valid.
   // The hook is applied after the entry numbered hook_at has been compared.
   task automatic run_trace(input int hook_kind, input int hook_at);
      exp_t e;
      int   idx;
      idx = 0;
      while (sb.size() > 0) begin
         @(negedge clk);
         abort    = 1'b0;
         force_en = 1'b0;
         rst      = 1'b1;
         #1;
         e = sb.pop_front();
         chk("count",     {4'b0, cnt_count}, {4'b0, e.cnt});
         chk("done",      {7'b0, done},      {7'b0, e.done});
         chk("busy",      {7'b0, busy},      {7'b0, e.busy});
         chk("cnt_rst",   {7'b0, cnt_rst},   {7'b0, e.crst});
         chk("cmd_ready", {7'b0, cmd_ready}, {7'b0, ~e.busy});
         if (e.done) chk("status", {6'b0, done_status}, {6'b0, e.st});
         if (idx == hook_at) begin
            case (hook_kind)
               1: abort     = 1'b1;
               2: force_en  = 1'b1;
               3: rst       = 1'b0;
               4: cmd_valid = 1'b0;
               default: ;
            endcase
         end
         idx++;
      end
   endtask

   initial begin
      rst       = 1'b0;
      cmd_valid = 1'b0;
      cmd_lo    = 4'd0;
      cmd_hi    = 4'd0;
      cmd_legs  = 8'd0;
      abort     = 1'b0;

      // Reset values
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_cnt_rst",  {7'b0, cnt_rst},     8'd1);
      chk("rst_cnt_updo", {7'b0, cnt_updo},    8'd1);
      chk("rst_done",     {7'b0, done},        8'd0);
      chk("rst_status",   {6'b0, done_status}, 8'd0);
      chk("rst_busy",     {7'b0, busy},        8'd0);
      chk("rst_ready",    {7'b0, cmd_ready},   8'd0);
      rst = 1'b1;
      #1;
      chk("ready_after_rst", {7'b0, cmd_ready}, 8'd1);

      // abort while idle is ignored
      @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("idle_abort_done", {7'b0, done}, 8'd0);
      chk("idle_abort_busy", {7'b0, busy}, 8'd0);
      $display("idle abort ignored");

      // lo=2 hi=5 legs=2: 0,1,2,3,4,5,4,3,2(done),0
      push_ramp(0, 5); push_ramp(4, 3); push_done(4'd2, 2'b00); push_idle(4'd0);
      issue(4'd2, 4'd5, 8'd2);
      run_trace(0, -1);

      // lo=0 hi=3 legs=3: straight to SWEEP
      push_ramp(0, 3); push_ramp(2, 0); push_ramp(1, 2); push_done(4'd3, 2'b00); push_idle(4'd0);
      issue(4'd0, 4'd3, 8'd3);
      run_trace(0, -1);

      // lo=7 hi=8 legs=4: alternating 7/8 after SEEK
      push_ramp(0, 8); push_ramp(7, 7); push_ramp(8, 8); push_done(4'd7, 2'b00); push_idle(4'd0);
      issue(4'd7, 4'd8, 8'd4);
      run_trace(0, -1);

      // bad commands: lo==hi, lo>hi, legs==0
      push_done(4'd0, 2'b10); push_idle(4'd0);
      issue(4'd5, 4'd5, 8'd2);
      run_trace(0, -1);
      push_done(4'd0, 2'b10); push_idle(4'd0);
      issue(4'd9, 4'd3, 8'd2);
      run_trace(0, -1);
      push_done(4'd0, 2'b10); push_idle(4'd0);
      issue(4'd2, 4'd5, 8'd0);
      run_trace(0, -1);

      // abort when count reads 4
      push_ramp(0, 4); push_done(4'd5, 2'b01); push_idle(4'd0);
      issue(4'd2, 4'd5, 8'd2);
      run_trace(1, 4);

      // out-of-range count during sweep
      push_ramp(0, 3); push_done(4'd4, 2'b11); push_idle(4'd0);
      issue(4'd2, 4'd5, 8'd2);
      run_trace(2, 3);

      // rst low mid-sweep: no done pulse, back to idle values
      push_ramp(0, 3); push_idle(4'd4); push_idle(4'd0);
      issue(4'd2, 4'd5, 8'd2);
      run_trace(3, 3);

      // hi-lo==1, legs=1, with a bad command held while busy
      push_ramp(0, 0); push_done(4'd1, 2'b00); push_done(4'd0, 2'b10); push_idle(4'd0);
      issue(4'd0, 4'd1, 8'd1);
      cmd_lo    = 4'd5;
      cmd_hi    = 4'd5;
      cmd_legs  = 8'd1;
      cmd_valid = 1'b1;
      run_trace(4, 2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
